// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and word type for the instruction memory loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, FIN} loader_state_t;
  localparam int WORD_BYTES = 4;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts stream bytes little-endian into a 32-bit word; full marks the lane that completes it
module byte_packer
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output word_t      word,
  output logic       full
);
  logic [1:0] cnt;
  assign full = cnt == 2'(WORD_BYTES - 1);
  // right shift so the first byte of a word ends up in bits [7:0]
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {din, word[31:8]};
    end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time byte stream to instruction memory writer with a 16-bit word count header
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
  loader_state_t state, state_n;
  logic [15:0] n, idx, hdr, idx_inc;
  logic xfer, take, full;
  word_t word;
  assign byte_ready = state inside {HDR0, HDR1, DATA};
  assign busy       = state != IDLE;
  assign xfer       = byte_valid && byte_ready;
  assign take       = start && state == IDLE;
  assign hdr        = {byte_data, n[7:0]};
  assign idx_inc    = idx + 16'd1;
  assign we         = state == WRITE;
  assign waddr      = we ? {14'd0, idx, 2'b00} : '0;
  assign wdata      = we ? word : '0;
  byte_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (take),
    .en   (xfer && state == DATA),
    .din  (byte_data),
    .word (word),
    .full (full)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? HDR0 : IDLE;
      HDR0:    state_n = xfer ? HDR1 : HDR0;
      HDR1:    if (xfer) state_n = hdr == 16'd0 ? FIN : (hdr > DEPTH_W ? IDLE : DATA);
      DATA:    state_n = xfer && full ? WRITE : DATA;
      WRITE:   state_n = idx_inc == n ? FIN : DATA;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      idx   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        idx  <= '0;
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (state == HDR0 && xfer) n[7:0] <= byte_data;
      if (state == HDR1 && xfer) begin
        n[15:8] <= byte_data;
        if (hdr > DEPTH_W) err <= 1'b1;
      end
      if (state == WRITE) idx <= idx_inc;
      if (state == FIN) done <= 1'b1;
    end
endmodule
